demux_stream_1xn: RTL and testbench
===================================

// Module: demux_stream_1xn
// PURPOSE
//   Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes.
//   Each beat is routed to one output lane selected by in_sel, or to all lanes when
//   broadcast is requested. Every lane has a one-entry output register with independent
//   backpressure. Sits between a single producer and N consumer channels; successor to
//   the combinational 1x32 demux, adding handshakes, broadcast and drop accounting.
// PARAMETERS
//   DATA_W   8    payload width in bits (>=1)
//   N_OUT    32   number of output lanes (2..64; need not be a power of two)
//   BCAST_EN 1    1 = in_bcast honoured; 0 = in_bcast ignored (treated as 0)
//   SEL_W    derived localparam = $clog2(N_OUT); not user-settable
// PORTS
//   clk        in   1             rising-edge clock, single clock domain
//   rst_n      in   1             synchronous reset, active-low
//   in_valid   in   1             producer beat valid
//   in_ready   out  1             block can accept the current beat
//   in_data    in   DATA_W        payload
//   in_sel     in   SEL_W         target lane index
//   in_bcast   in   1             deliver beat to every lane
//   out_valid  out  N_OUT         per-lane valid; bit k = lane k
//   out_ready  in   N_OUT         per-lane consumer ready
//   out_data   out  N_OUT*DATA_W  lane k occupies [k*DATA_W +: DATA_W]
//   drop_cnt   out  16            count of dropped beats (out-of-range sel), saturating
// BEHAVIOUR
//   - Reset (rst_n=0 at a rising edge): all out_valid=0, out_data=0, drop_cnt=0. Held
//     beats are discarded. in_ready is 0 while rst_n=0. Mid-operation reset behaves
//     identically; there is no partial-delivery recovery.
//   - Lane k can_accept = !out_valid[k] | out_ready[k] (full throughput: refill on drain).
//   - Handshakes: input accept = in_valid & in_ready; lane k drain = out_valid[k] & out_ready[k].
//   - in_ready is combinational from in_sel/in_bcast/out_ready/out_valid, never from
//     in_valid. Values:
//       bcast (in_bcast & BCAST_EN): AND of can_accept over all lanes;
//       unicast, in_sel < N_OUT: can_accept[in_sel];
//       unicast, in_sel >= N_OUT: 1 (beat is sunk).
//   - On accept, unicast: lane in_sel loads in_data, out_valid[in_sel]<=1 at the next edge.
//     Bcast: every lane loads in_data and sets valid at the same edge (atomic, all or none).
//     Out-of-range: no lane changes; drop_cnt increments, saturating at 16'hFFFF.
//   - Latency: beat accepted at edge k is visible on out_valid/out_data after edge k.
//   - Lane not loaded this edge: if drained, out_valid[k]<=0; else holds. out_data holds its
//     last value when invalid (not cleared).
//   - Drain and load of the same lane on one edge: new beat wins (valid stays 1).
//   - out_data/out_valid are stable while out_valid=1 and out_ready=0 (no overwrite:
//     can_accept is 0).
//   - Producer rule: once in_valid=1, in_data/in_sel/in_bcast hold until accepted.
//   - Ordering: per-lane beats leave in acceptance order; no cross-lane ordering guarantee.
//   - No combinational path from in_* to out_*; all outputs except in_ready are registered.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, drop_cnt=0.
//   2 Sweep: for sel=0..31 send data=sel+8'hA0 with all out_ready=1 -> exactly one cycle
//     later out_valid=(1<<sel) and lane sel data=sel+8'hA0; in_ready=1 each cycle.
//   3 Backpressure: out_ready[5]=0, send two beats to lane 5 (8'h11, 8'h22) -> first held,
//     in_ready=0 for second; raise out_ready[5] -> 8'h11 drains, 8'h22 loads same edge.
//   4 Broadcast: in_bcast=1, data=8'h5A, out_ready[31]=0 with lane 31 full -> in_ready=0,
//     no lane changes; release lane 31 -> all 32 lanes show 8'h5A next cycle.
//   5 Out-of-range: N_OUT=20, in_sel=25, 3 beats -> in_ready=1, no out_valid change,
//     drop_cnt=3; force drop_cnt to 16'hFFFF, drop one more -> stays 16'hFFFF.
//   6 Mid-op reset: lanes 3 and 7 full, assert rst_n=0 one cycle -> out_valid=0 next
//     cycle, out_data all 0, no stale beats delivered.

Source files
------------

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N stream demultiplexer with per-lane one-entry output registers,
// optional broadcast, and a saturating counter for beats whose lane index is out of range.

module demux_stream_lane #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              can_accept
);
   // A lane can be refilled on the same edge it drains, so it never stalls a full-rate stream.
   assign can_accept = !valid | ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end
endmodule

module demux_stream_1xn #(
   parameter  int DATA_W   = 8,
   parameter  int N_OUT    = 32,
   parameter  int BCAST_EN = 1,
   localparam int SEL_W    = $clog2(N_OUT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_bcast,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic [15:0]             drop_cnt
);
   localparam int EXT_W = SEL_W + 1;

   logic [N_OUT-1:0] can_accept;
   logic [N_OUT-1:0] sel_hot;
   logic [N_OUT-1:0] load;
   logic             bcast;
   logic             in_range;
   logic             accept;
   logic             drop;

   assign bcast    = in_bcast & (BCAST_EN != 0);
   assign in_range = ({1'b0, in_sel} < EXT_W'(N_OUT));

   // Out-of-range unicast beats are always accepted and sunk so the producer cannot wedge.
   assign in_ready = rst_n & (bcast ? (&can_accept) : (!in_range | (|(sel_hot & can_accept))));
   assign accept   = in_valid & in_ready;
   assign drop     = accept & !bcast & !in_range;

   for (genvar k = 0; k < N_OUT; k++) begin : g_lane
      assign sel_hot[k] = (in_sel == SEL_W'(k));
      assign load[k]    = accept & (bcast | sel_hot[k]);

      demux_stream_lane #(.DATA_W(DATA_W)) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .load       (load[k]),
         .load_data  (in_data),
         .ready      (out_ready[k]),
         .valid      (out_valid[k]),
         .data       (out_data[k*DATA_W +: DATA_W]),
         .can_accept (can_accept[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         drop_cnt <= '0;
      else if (drop && drop_cnt != 16'hFFFF)
         drop_cnt <= drop_cnt + 16'd1;
   end
endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: a 32-lane instance for the directed sequences and a
// 20-lane instance for out-of-range drops and randomized traffic against a lane model.

module tb_demux_stream_1xn;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 32-lane instance
   logic         in_valid_a, in_ready_a, in_bcast_a;
   logic [7:0]   in_data_a;
   logic [4:0]   in_sel_a;
   logic [31:0]  out_valid_a, out_ready_a;
   logic [255:0] out_data_a;
   logic [15:0]  drop_cnt_a;

   // 20-lane instance
   logic         in_valid_b, in_ready_b, in_bcast_b;
   logic [7:0]   in_data_b;
   logic [4:0]   in_sel_b;
   logic [19:0]  out_valid_b, out_ready_b;
   logic [159:0] out_data_b;
   logic [15:0]  drop_cnt_b;

   demux_stream_1xn #(.DATA_W(8), .N_OUT(32), .BCAST_EN(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_data(in_data_a), .in_sel(in_sel_a), .in_bcast(in_bcast_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
      .drop_cnt(drop_cnt_a));

   demux_stream_1xn #(.DATA_W(8), .N_OUT(20), .BCAST_EN(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_data(in_data_b), .in_sel(in_sel_b), .in_bcast(in_bcast_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .drop_cnt(drop_cnt_b));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [4:0]  sel;
      logic [7:0]  data;
      logic [31:0] exp_valid;
      logic [7:0]  exp_data;
   } sweep_vec_t;

   sweep_vec_t sweep[32];

   // Reference model for the 20-lane instance
   bit         mv[20];
   logic [7:0] md[20];
   int         mdrop;

   task automatic model_reset();
      for (int k = 0; k < 20; k++) begin mv[k] = 0; md[k] = 8'h00; end
      mdrop = 0;
   endtask

   // Called at the negedge with the inputs that the next rising edge will sample.
   task automatic model_check_and_step();
      bit          can[20];
      bit          all_can, exp_rdy, acc;
      logic [19:0] ev;
      logic [159:0] ed;
      int          s;
      s = int'(in_sel_b);
      all_can = 1;
      for (int k = 0; k < 20; k++) begin
         can[k] = !mv[k] || out_ready_b[k];
         all_can &= can[k];
         ev[k] = mv[k];
         ed[k*8 +: 8] = md[k];
      end
      if (in_bcast_b)  exp_rdy = all_can;
      else if (s < 20) exp_rdy = can[s];
      else             exp_rdy = 1;
      chk("rnd_in_ready", {255'd0, in_ready_b}, {255'd0, exp_rdy});
      chk("rnd_out_valid", {236'd0, out_valid_b}, {236'd0, ev});
      chk("rnd_out_data", {96'd0, out_data_b}, {96'd0, ed});
      chk("rnd_drop_cnt", {240'd0, drop_cnt_b}, 256'(mdrop));
      acc = in_valid_b && exp_rdy;
      for (int k = 0; k < 20; k++) begin
         if (acc && (in_bcast_b || s == k)) begin mv[k] = 1; md[k] = in_data_b; end
         else if (out_ready_b[k]) mv[k] = 0;
      end
      if (acc && !in_bcast_b && s >= 20 && mdrop < 16'hFFFF) mdrop++;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         sweep[i].sel       = 5'(i);
         sweep[i].data      = 8'(i) + 8'hA0;
         sweep[i].exp_valid = 32'd1 << i;
         sweep[i].exp_data  = 8'(i) + 8'hA0;
      end

      rst_n = 1'b0;
      in_valid_a = 1'b1; in_bcast_a = 1'b0; in_data_a = 8'h00; in_sel_a = 5'd0;
      out_ready_a = '1;
      in_valid_b = 1'b1; in_bcast_b = 1'b0; in_data_b = 8'h00; in_sel_b = 5'd0;
      out_ready_b = '1;

      // 1: reset with in_valid asserted
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_in_ready_a", {255'd0, in_ready_a}, 256'd0);
      chk("rst_in_ready_b", {255'd0, in_ready_b}, 256'd0);
      chk("rst_out_valid_a", {224'd0, out_valid_a}, 256'd0);
      chk("rst_out_data_a", out_data_a, 256'd0);
      chk("rst_drop_cnt_b", {240'd0, drop_cnt_b}, 256'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;

      // 2: sweep every lane
      for (int i = 0; i < 32; i++) begin
         in_valid_a = 1'b1; in_sel_a = sweep[i].sel; in_data_a = sweep[i].data;
         @(negedge clk);
         chk("sweep_in_ready", {255'd0, in_ready_a}, 256'd1);
         next_cycle();
         in_valid_a = 1'b0;
         @(negedge clk);
         chk("sweep_valid", {224'd0, out_valid_a}, {224'd0, sweep[i].exp_valid});
         chk("sweep_data", {248'd0, out_data_a[int'(sweep[i].sel)*8 +: 8]}, {248'd0, sweep[i].exp_data});
      end
      next_cycle();

      // 3: backpressure on lane 5
      out_ready_a = '1; out_ready_a[5] = 1'b0;
      in_valid_a = 1'b1; in_sel_a = 5'd5; in_data_a = 8'h11;
      @(negedge clk);
      chk("bp_first_ready", {255'd0, in_ready_a}, 256'd1);
      next_cycle();
      in_data_a = 8'h22;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("bp_second_blocked", {255'd0, in_ready_a}, 256'd0);
         chk("bp_held_valid", {224'd0, out_valid_a}, 256'h20);
         chk("bp_held_data", {248'd0, out_data_a[40 +: 8]}, 256'h11);
         next_cycle();
      end
      out_ready_a[5] = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", {255'd0, in_ready_a}, 256'd1);
      next_cycle();
      in_valid_a = 1'b0;
      @(negedge clk);
      chk("bp_refill_valid", {224'd0, out_valid_a}, 256'h20);
      chk("bp_refill_data", {248'd0, out_data_a[40 +: 8]}, 256'h22);
      next_cycle();
      @(negedge clk);
      chk("bp_drained", {224'd0, out_valid_a}, 256'd0);

      // 4: broadcast blocked by a full lane 31
      out_ready_a = '1; out_ready_a[31] = 1'b0;
      in_valid_a = 1'b1; in_sel_a = 5'd31; in_data_a = 8'h77;
      next_cycle();
      in_bcast_a = 1'b1; in_data_a = 8'h5A;
      @(negedge clk);
      chk("bc_blocked_ready", {255'd0, in_ready_a}, 256'd0);
      next_cycle();
      @(negedge clk);
      chk("bc_blocked_valid", {224'd0, out_valid_a}, 256'h8000_0000);
      chk("bc_blocked_lane31", {248'd0, out_data_a[248 +: 8]}, 256'h77);
      chk("bc_blocked_lane0", {248'd0, out_data_a[0 +: 8]}, 256'hA0);
      out_ready_a[31] = 1'b1;
      @(negedge clk);
      chk("bc_release_ready", {255'd0, in_ready_a}, 256'd1);
      next_cycle();
      in_valid_a = 1'b0; in_bcast_a = 1'b0;
      @(negedge clk);
      chk("bc_all_valid", {224'd0, out_valid_a}, {224'd0, 32'hFFFF_FFFF});
      chk("bc_all_data", out_data_a, {32{8'h5A}});
      next_cycle();

      // 5: out-of-range drops on the 20-lane instance
      in_valid_b = 1'b1; in_sel_b = 5'd25; in_data_b = 8'hEE; in_bcast_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("oor_in_ready", {255'd0, in_ready_b}, 256'd1);
         chk("oor_no_valid", {236'd0, out_valid_b}, 256'd0);
         next_cycle();
      end
      in_valid_b = 1'b0;
      @(negedge clk);
      chk("oor_drop3", {240'd0, drop_cnt_b}, 256'd3);
      chk("oor_data_untouched", {96'd0, out_data_b}, 256'd0);
      force dut_b.drop_cnt = 16'hFFFF;
      next_cycle();
      release dut_b.drop_cnt;
      @(negedge clk);
      chk("oor_forced", {240'd0, drop_cnt_b}, 256'hFFFF);
      next_cycle();
      in_valid_b = 1'b1;
      next_cycle();
      in_valid_b = 1'b0;
      @(negedge clk);
      chk("oor_saturate", {240'd0, drop_cnt_b}, 256'hFFFF);

      // randomized traffic on the 20-lane instance against the model
      next_cycle();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 2000; c++) begin
         if (!(in_valid_b && !in_ready_b)) begin
            in_valid_b = ($urandom_range(0, 9) < 7);
            in_sel_b   = 5'($urandom_range(0, 31));
            in_bcast_b = ($urandom_range(0, 7) == 0);
            in_data_b  = 8'($urandom);
         end
         out_ready_b = 20'($urandom) | ((c % 200 < 100) ? 20'h0 : 20'($urandom));
         @(negedge clk);
         model_check_and_step();
         next_cycle();
      end
      in_valid_b = 1'b0;

      // 6: mid-operation reset with lanes 3 and 7 full
      out_ready_a = '0;
      in_valid_a = 1'b1; in_sel_a = 5'd3; in_data_a = 8'h33;
      next_cycle();
      in_sel_a = 5'd7; in_data_a = 8'h77;
      next_cycle();
      in_valid_a = 1'b0;
      @(negedge clk);
      chk("mid_full", {224'd0, out_valid_a}, 256'h88);
      next_cycle();
      rst_n = 1'b0;
      in_valid_a = 1'b1; in_sel_a = 5'd9; in_data_a = 8'h99;
      @(negedge clk);
      chk("mid_rst_ready", {255'd0, in_ready_a}, 256'd0);
      next_cycle();
      rst_n = 1'b1; in_valid_a = 1'b0; out_ready_a = '1;
      @(negedge clk);
      chk("mid_rst_valid", {224'd0, out_valid_a}, 256'd0);
      chk("mid_rst_data", out_data_a, 256'd0);
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         @(negedge clk);
         chk("mid_no_stale", {224'd0, out_valid_a}, 256'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
